ifetch_buffer: RTL and testbench

IFETCH_BUFFER -- requirements
Module: ifetch_buffer

---
 rtl/ifetch_buffer_if.sv | 27 ++
 rtl/ifetch_buffer.sv | 125 ++++++++++++
 tb/tb_ifetch_buffer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_buffer_if.sv
// rtl/ifetch_buffer_if.sv - fetch-buffer bus: redirect, instruction-memory and cpu-side signals
interface ifetch_buffer_if #(
    parameter int DEPTH = 4
);
    logic                     redirect_valid;
    logic [31:0]              redirect_pc;
    logic                     mem_req;
    logic [31:0]              mem_addr;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [31:0]              mem_rdata;
    logic                     inst_valid;
    logic [31:0]              inst_data;
    logic [31:0]              inst_pc;
    logic                     inst_ready;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport slave (
        input  redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc, fifo_count
    );

    modport master (
        output redirect_valid, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, fifo_count
    );
endinterface

// File: rtl/ifetch_buffer.sv
// rtl/ifetch_buffer.sv - instruction prefetch FIFO with in-order memory responses and redirect flush
module ifetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_buffer_if.slave bus
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_S = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          mem_req_w;
    logic          rsp_kept;
    logic          accept;
    logic          pop;
    logic          push;
    logic [CW:0]   occupancy;
    logic [CW-1:0] outst_after_rsp;
    logic [31:0]   redirect_target;

    // Slots already promised to in-flight requests count as occupied.
    assign occupancy       = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_w       = !bus.redirect_valid && (occupancy < DEPTH_S);
    assign rsp_kept        = bus.mem_rvalid && (outst_q != '0);
    assign accept          = mem_req_w && bus.mem_gnt;
    assign pop             = (count_q != '0) && bus.inst_ready;
    assign outst_after_rsp = rsp_kept ? (outst_q - ONE) : outst_q;
    assign redirect_target = bus.redirect_pc & ~32'h0000_0003;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        push       = 1'b0;

        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle's response is stale.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            outst_d    = outst_after_rsp;
            discard_d  = outst_after_rsp;
        end else begin
            outst_d = accept ? (outst_after_rsp + ONE) : outst_after_rsp;
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_kept) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - ONE;
                end else begin
                    push = 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PTR_ONE;
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.mem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign bus.mem_req    = mem_req_w;
    assign bus.mem_addr   = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst_data  = data_mem[rd_ptr_q];
    assign bus.inst_pc    = pc_mem[rd_ptr_q];
    assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb/tb_ifetch_buffer.sv - directed scoreboard bench for ifetch_buffer
module tb_ifetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] pipe_q [$];
    logic [31:0] exp_addr;
    int          grants_left;
    bit          resp_en;
    int          n;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // One clock: drive memory side, sample at negedge+1, advance to next negedge.
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        logic [31:0] e;
        if (resp_en && pipe_q.size() != 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_word(pipe_q.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = '0;
        end
        bus.mem_gnt = (grants_left != 0);
        #1;
        if (bus.redirect_valid) check("req_low_on_redirect", 32'(bus.mem_req), 32'd0);
        if (bus.inst_valid && bus.inst_ready) begin
            check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("inst_pc", bus.inst_pc, e);
                check("inst_data", bus.inst_data, mem_word(e));
            end
        end
        acc = bus.mem_req && bus.mem_gnt;
        a   = bus.mem_addr;
        if (acc) begin
            check("mem_addr", a, exp_addr);
            exp_addr = exp_addr + 32'd4;
            grants_left--;
        end
        @(posedge clk);
        if (acc) pipe_q.push_back(a);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit clear_pipe);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.mem_rvalid     = 1'b0;
        exp_q.delete();
        if (clear_pipe) pipe_q.delete();
        #1;
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd1);
        check("rst_mem_addr", bus.mem_addr, RESET_PC);
        check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_addr = RESET_PC;
    endtask

    task automatic run_until_empty(input int bound, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < bound) begin
            cycle();
            cycles++;
        end
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_gnt        = 1'b0;
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = '0;
        bus.inst_ready     = 1'b0;
        grants_left        = 0;
        resp_en            = 1'b0;
        exp_addr           = RESET_PC;
        @(negedge clk);

        // Streaming, one instruction per cycle after a two-cycle fill
        do_reset(1'b1);
        bus.inst_ready = 1'b1;
        resp_en        = 1'b1;
        grants_left    = 8;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        run_until_empty(50, n);
        check("stream_cycles", 32'(n), 32'd10);

        // Back-pressure fills to DEPTH, then drains on consecutive cycles
        do_reset(1'b1);
        bus.inst_ready = 1'b0;
        resp_en        = 1'b1;
        grants_left    = 100;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        repeat (8) cycle();
        check("bp_mem_req", 32'(bus.mem_req), 32'd0);
        check("bp_fifo_count", 32'(bus.fifo_count), 32'd4);
        check("bp_inst_pc", bus.inst_pc, 32'h0);
        check("bp_accepts", exp_addr, 32'd16);
        grants_left    = 0;
        bus.inst_ready = 1'b1;
        run_until_empty(20, n);
        check("bp_drain_cycles", 32'(n), 32'd4);

        // Flush with two requests outstanding
        do_reset(1'b1);
        bus.inst_ready = 1'b1;
        resp_en        = 1'b0;
        grants_left    = 2;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        check("flush_mem_addr", bus.mem_addr, 32'h0000_0100);
        exp_addr = 32'h0000_0100;
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0104);
        resp_en     = 1'b1;
        grants_left = 2;
        run_until_empty(20, n);
        check("flush_cycles", 32'(n), 32'd5);

        // Unaligned redirect target and address wrap
        do_reset(1'b1);
        bus.inst_ready     = 1'b1;
        resp_en            = 1'b1;
        grants_left        = 2;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        check("wrap_mem_addr", bus.mem_addr, 32'hFFFF_FFFC);
        exp_addr = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        run_until_empty(20, n);
        check("wrap_cycles", 32'(n), 32'd4);

        // Redirect, response and pop in the same cycle
        do_reset(1'b1);
        bus.inst_ready = 1'b0;
        resp_en        = 1'b1;
        grants_left    = 2;
        exp_q.push_back(32'h0);
        repeat (2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        bus.inst_ready     = 1'b1;
        cycle();
        bus.redirect_valid = 1'b0;
        #1;
        check("sim_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("sim_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("sim_head_consumed", 32'(exp_q.size()), 32'd0);
        check("sim_mem_addr", bus.mem_addr, 32'h0000_0200);
        exp_addr = 32'h0000_0200;
        exp_q.push_back(32'h0000_0200);
        grants_left = 1;
        run_until_empty(10, n);
        check("sim_cycles", 32'(n), 32'd3);

        // Reset mid-run with entries buffered and requests in flight
        do_reset(1'b1);
        bus.inst_ready = 1'b0;
        resp_en        = 1'b1;
        grants_left    = 2;
        repeat (3) cycle();
        resp_en     = 1'b0;
        grants_left = 2;
        repeat (2) cycle();
        check("mid_fifo_count", 32'(bus.fifo_count), 32'd2);
        check("mid_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("mid_pending", 32'(pipe_q.size()), 32'd2);
        do_reset(1'b0);
        bus.inst_ready = 1'b1;
        resp_en        = 1'b1;
        grants_left    = 0;
        repeat (3) cycle();
        check("late_rsp_fifo_count", 32'(bus.fifo_count), 32'd0);
        check("late_rsp_inst_valid", 32'(bus.inst_valid), 32'd0);
        exp_q.push_back(RESET_PC);
        grants_left = 1;
        run_until_empty(10, n);
        check("post_reset_cycles", 32'(n), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
